// File: rtl/cpu_state_scanner.sv
// cpu_state_scanner
//   Debug-side walker for the single-cycle CPU display ports. A start pulse
//   snapshots PC and instruction. The block then walks all 32 registers and
//   MEM_WORDS data words, and emits each value as a tagged word on a
//   valid/ready stream.
//
//   Stream tags:
//     8'h80     PC snapshot
//     8'h81     instruction snapshot
//     8'h00+i   register i
//     8'h40+j   data word j, at MEM_BASE + 4*j
//
//   Optional feature: define SCAN_SKIP_ZERO_EN to drop register and memory
//   entries that read as zero, and to always drop r0.
//
// Parameters:
//   MEM_WORDS  number of data words scanned (1..32)
//   MEM_BASE   byte address of the first scanned word (word aligned)
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   start                frame request, honoured only in IDLE
//   rf_addr / rf_data    register display port (data is combinational)
//   mem_addr / mem_data  memory display port (data is combinational)
//   cpu_pc, cpu_inst     live CPU PC and instruction
//   out_valid/out_ready  stream handshake
//   out_tag, out_data    stream payload
//   busy                 frame in progress
//   done                 one-cycle pulse after the last word transfers

module cpu_state_scanner #(
  parameter int unsigned MEM_WORDS = 32,
  parameter logic [31:0] MEM_BASE  = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  output logic [4:0]  rf_addr,
  output logic [31:0] mem_addr,
  input  logic [31:0] rf_data,
  input  logic [31:0] mem_data,
  input  logic [31:0] cpu_pc,
  input  logic [31:0] cpu_inst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_tag,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        done
);

  localparam int unsigned IDX_W    = 5;
  localparam int unsigned DATA_W   = 32;
  localparam logic [IDX_W-1:0] RF_LAST  = 5'd31;
  localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'(MEM_WORDS - 1);
  localparam logic [7:0] TAG_PC   = 8'h80;
  localparam logic [7:0] TAG_INST = 8'h81;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EMIT_PC,
    S_EMIT_INST,
    S_RF_RD,
    S_RF_EMIT,
    S_MEM_RD,
    S_MEM_EMIT,
    S_FIN
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [DATA_W-1:0]  pc_snap;
  logic [DATA_W-1:0]  inst_snap;

  logic               xfer_c;
  logic [IDX_W-1:0]   idx_inc_c;
  logic               rf_skip_c;
  logic               mem_skip_c;

  // Byte address of scanned data word i.
  function automatic logic [31:0] word_addr(input logic [IDX_W-1:0] i);
    return MEM_BASE + {25'd0, i, 2'b00};
  endfunction

  assign xfer_c    = out_valid & out_ready;
  assign idx_inc_c = idx + 5'd1;

  // Zero-skip decision on the value read live in the RD state.
`ifdef SCAN_SKIP_ZERO_EN
  assign rf_skip_c  = (idx == '0) || (rf_data == '0);
  assign mem_skip_c = (mem_data == '0);
`else
  assign rf_skip_c  = 1'b0;
  assign mem_skip_c = 1'b0;
`endif

  // Scan sequencer; all outputs registered.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      idx       <= '0;
      pc_snap   <= '0;
      inst_snap <= '0;
      rf_addr   <= '0;
      mem_addr  <= MEM_BASE;
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            pc_snap   <= cpu_pc;
            inst_snap <= cpu_inst;
            out_valid <= 1'b1;
            out_tag   <= TAG_PC;
            out_data  <= cpu_pc;
            busy      <= 1'b1;
            state     <= S_EMIT_PC;
          end
        end

        S_EMIT_PC: begin
          if (xfer_c) begin
            out_tag  <= TAG_INST;
            out_data <= inst_snap;
            state    <= S_EMIT_INST;
          end else begin
            out_data <= pc_snap;
          end
        end

        S_EMIT_INST: begin
          if (xfer_c) begin
            out_valid <= 1'b0;
            idx       <= '0;
            rf_addr   <= '0;
            state     <= S_RF_RD;
          end
        end

        S_RF_RD: begin
          if (rf_skip_c) begin
            if (idx == RF_LAST) begin
              idx      <= '0;
              mem_addr <= word_addr('0);
              state    <= S_MEM_RD;
            end else begin
              idx     <= idx_inc_c;
              rf_addr <= idx_inc_c;
            end
          end else begin
            out_valid <= 1'b1;
            out_tag   <= {3'b000, idx};
            out_data  <= rf_data;
            state     <= S_RF_EMIT;
          end
        end

        S_RF_EMIT: begin
          if (xfer_c) begin
            out_valid <= 1'b0;
            if (idx == RF_LAST) begin
              idx      <= '0;
              mem_addr <= word_addr('0);
              state    <= S_MEM_RD;
            end else begin
              idx     <= idx_inc_c;
              rf_addr <= idx_inc_c;
              state   <= S_RF_RD;
            end
          end
        end

        S_MEM_RD: begin
          if (mem_skip_c) begin
            if (idx == MEM_LAST) begin
              done  <= 1'b1;
              state <= S_FIN;
            end else begin
              idx      <= idx_inc_c;
              mem_addr <= word_addr(idx_inc_c);
            end
          end else begin
            out_valid <= 1'b1;
            out_tag   <= {3'b010, idx};
            out_data  <= mem_data;
            state     <= S_MEM_EMIT;
          end
        end

        S_MEM_EMIT: begin
          if (xfer_c) begin
            out_valid <= 1'b0;
            if (idx == MEM_LAST) begin
              done  <= 1'b1;
              state <= S_FIN;
            end else begin
              idx      <= idx_inc_c;
              mem_addr <= word_addr(idx_inc_c);
              state    <= S_MEM_RD;
            end
          end
        end

        S_FIN: begin
          // Start is deliberately not sampled here; busy drops as IDLE is re-entered.
          idx      <= '0;
          rf_addr  <= '0;
          mem_addr <= MEM_BASE;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_state_scanner.sv
// Randomized bench for cpu_state_scanner. Two instances are used: the default
// (32 words at 0) and a small one (4 words at 32'h10). The reference model
// builds the expected word list of a frame straight from the scan rules, and
// it predicts the frame length from per-entry costs.
module tb_cpu_state_scanner;

  localparam int unsigned MW_B   = 4;
  localparam logic [31:0] BASE_B = 32'h10;
`ifdef SCAN_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct {
    logic [7:0]  tag;
    logic [31:0] data;
    logic [31:0] addr;
    int          kind;   // 0 header, 1 register, 2 memory
  } word_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, start, out_ready, sel;
  logic [31:0] cpu_pc, cpu_inst;
  logic        start_a, start_b;

  logic [4:0]  a_rf_addr, b_rf_addr;
  logic [31:0] a_mem_addr, b_mem_addr, a_rf_data, b_rf_data, a_mem_data, b_mem_data;
  logic        a_valid, b_valid, a_busy, b_busy, a_done, b_done;
  logic [7:0]  a_tag, b_tag;
  logic [31:0] a_data, b_data;

  logic [31:0] rf  [32];
  logic [31:0] mem [64];

  assign start_a    = start & ~sel;
  assign start_b    = start & sel;
  assign a_rf_data  = rf[a_rf_addr];
  assign b_rf_data  = rf[b_rf_addr];
  assign a_mem_data = mem[a_mem_addr[7:2]];
  assign b_mem_data = mem[b_mem_addr[7:2]];

  cpu_state_scanner u_a (
    .clk(clk), .resetn(resetn), .start(start_a),
    .rf_addr(a_rf_addr), .mem_addr(a_mem_addr),
    .rf_data(a_rf_data), .mem_data(a_mem_data),
    .cpu_pc(cpu_pc), .cpu_inst(cpu_inst),
    .out_valid(a_valid), .out_ready(out_ready),
    .out_tag(a_tag), .out_data(a_data),
    .busy(a_busy), .done(a_done)
  );

  cpu_state_scanner #(.MEM_WORDS(MW_B), .MEM_BASE(BASE_B)) u_b (
    .clk(clk), .resetn(resetn), .start(start_b),
    .rf_addr(b_rf_addr), .mem_addr(b_mem_addr),
    .rf_data(b_rf_data), .mem_data(b_mem_data),
    .cpu_pc(cpu_pc), .cpu_inst(cpu_inst),
    .out_valid(b_valid), .out_ready(out_ready),
    .out_tag(b_tag), .out_data(b_data),
    .busy(b_busy), .done(b_done)
  );

  // View of whichever instance is under test.
  logic        o_valid, o_busy, o_done;
  logic [7:0]  o_tag;
  logic [31:0] o_data, o_mem_addr;
  logic [4:0]  o_rf_addr;
  assign o_valid    = sel ? b_valid    : a_valid;
  assign o_busy     = sel ? b_busy     : a_busy;
  assign o_done     = sel ? b_done     : a_done;
  assign o_tag      = sel ? b_tag      : a_tag;
  assign o_data     = sel ? b_data     : a_data;
  assign o_mem_addr = sel ? b_mem_addr : a_mem_addr;
  assign o_rf_addr  = sel ? b_rf_addr  : a_rf_addr;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_reset_state();
    check_eq("rst_valid_a", 32'(a_valid), 32'd0);
    check_eq("rst_tag_a",   32'(a_tag),   32'd0);
    check_eq("rst_data_a",  a_data,       32'd0);
    check_eq("rst_busy_a",  32'(a_busy),  32'd0);
    check_eq("rst_done_a",  32'(a_done),  32'd0);
    check_eq("rst_rf_a",    32'(a_rf_addr), 32'd0);
    check_eq("rst_mem_a",   a_mem_addr,   32'h0);
    check_eq("rst_valid_b", 32'(b_valid), 32'd0);
    check_eq("rst_busy_b",  32'(b_busy),  32'd0);
    check_eq("rst_mem_b",   b_mem_addr,   BASE_B);
  endtask

  // mode: 0 ready held high (cycle count checked), 1 random ready,
  //       2 ready held low for 5 cycles while register 3 is offered.
  // noise pulses start mid-frame and in the FIN cycle; abort7 resets at mem word 7.
  task automatic run_frame(input bit use_b, input int mode, input bit noise,
                           input bit abort7, input logic [31:0] pc, input logic [31:0] inst);
    word_t       q[$];
    int unsigned mw;
    logic [31:0] base, a, v;
    int          exp_edges, edges, stall;
    bit          emit, prev_stall, xfer, fin;

    mw        = use_b ? MW_B : 32;
    base      = use_b ? BASE_B : 32'h0;
    exp_edges = 2;
    q.push_back('{tag: 8'h80, data: pc,   addr: 32'h0, kind: 0});
    q.push_back('{tag: 8'h81, data: inst, addr: 32'h0, kind: 0});
    for (int i = 0; i < 32; i++) begin
      emit = !SKIP || (i != 0 && rf[i] != 32'h0);
      exp_edges += emit ? 2 : 1;
      if (emit) q.push_back('{tag: 8'(i), data: rf[i], addr: 32'(i), kind: 1});
    end
    for (int j = 0; j < int'(mw); j++) begin
      a    = base + 32'(4 * j);
      v    = mem[a[7:2]];
      emit = !SKIP || v != 32'h0;
      exp_edges += emit ? 2 : 1;
      if (emit) q.push_back('{tag: 8'h40 + 8'(j), data: v, addr: a, kind: 2});
    end

    sel       = use_b;
    cpu_pc    = pc;
    cpu_inst  = inst;
    out_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    cpu_pc     = $urandom;   // snapshot must not follow the live inputs
    cpu_inst   = $urandom;
    edges      = 0;
    stall      = 0;
    prev_stall = 1'b0;
    fin        = 1'b0;

    while (!fin) begin
      if (o_valid) begin
        if (q.size() == 0) begin
          check_eq("extra_word", 32'(o_valid), 32'd0);
        end else begin
          check_eq("word_tag",  32'(o_tag), 32'(q[0].tag));
          check_eq("word_data", o_data, q[0].data);
          if (q[0].kind == 1) check_eq("rf_addr", 32'(o_rf_addr), q[0].addr);
          if (q[0].kind == 2) check_eq("mem_addr", o_mem_addr, q[0].addr);
        end
      end else if (prev_stall) begin
        check_eq("valid_held", 32'(o_valid), 32'd1);
      end
      if (o_done) begin
        check_eq("done_all_sent", 32'(q.size()), 32'd0);
        check_eq("busy_in_fin", 32'(o_busy), 32'd1);
        if (mode == 0) check_eq("done_cycle", 32'(edges), 32'(exp_edges));
        if (mode == 2) check_eq("stall_len", 32'(stall), 32'd5);
        fin = 1'b1;
      end else begin
        if (edges > 3000) begin
          check_eq("frame_timeout", 32'(edges), 32'(exp_edges));
          start = 1'b0;
          return;
        end
        case (mode)
          0:       out_ready = 1'b1;
          1:       out_ready = ($urandom_range(2) != 0);
          default: begin
            out_ready = !(o_valid && o_tag == 8'h03 && stall < 5);
            if (!out_ready) stall++;
          end
        endcase
        start = noise && o_valid && (o_tag == 8'h05 || $urandom_range(15) == 0);
        if (abort7 && o_valid && o_tag == 8'h47) begin
          resetn = 1'b0;
          @(posedge clk); #1;
          resetn = 1'b1;
          start  = 1'b0;
          check_eq("abort_valid", 32'(o_valid), 32'd0);
          check_eq("abort_busy",  32'(o_busy),  32'd0);
          check_eq("abort_done",  32'(o_done),  32'd0);
          check_eq("abort_tag",   32'(o_tag),   32'd0);
          check_eq("abort_data",  o_data,       32'd0);
          check_eq("abort_mem",   o_mem_addr,   base);
          return;
        end
        xfer       = o_valid && out_ready;
        prev_stall = o_valid && !out_ready;
        @(posedge clk); #1;
        edges++;
        if (xfer && q.size() != 0) void'(q.pop_front());
      end
    end

    // FIN cycle: a start pulse here must be ignored.
    start     = noise;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("post_busy",  32'(o_busy),  32'd0);
    check_eq("post_valid", 32'(o_valid), 32'd0);
    check_eq("post_done",  32'(o_done),  32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check_eq("idle_valid", 32'(o_valid), 32'd0);
      check_eq("idle_done",  32'(o_done),  32'd0);
    end
  endtask

  task automatic fill_random(input int zero_pct);
    for (int i = 0; i < 32; i++)
      rf[i] = ($urandom_range(99) < zero_pct) ? 32'h0 : ($urandom | 32'h1);
    rf[0] = 32'h0;
    for (int i = 0; i < 64; i++)
      mem[i] = ($urandom_range(99) < zero_pct) ? 32'h0 : ($urandom | 32'h1);
  endtask

  initial begin
    resetn    = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    sel       = 1'b0;
    cpu_pc    = 32'h0;
    cpu_inst  = 32'h0;
    fill_random(0);
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    resetn = 1'b1;
    @(posedge clk); #1;

    // Full frame, ready held high, known PC/instruction.
    rf[3] = 32'hDEAD_BEEF;
    run_frame(1'b0, 0, 1'b0, 1'b0, 32'h0000_0014, 32'h2401_0005);
    // Consumer stalls 5 cycles on register 3.
    run_frame(1'b0, 2, 1'b0, 1'b0, $urandom, $urandom);
    // Small instance: base 0x10, 4 words.
    run_frame(1'b1, 0, 1'b0, 1'b0, $urandom, $urandom);
    run_frame(1'b1, 1, 1'b0, 1'b0, $urandom, $urandom);
    // Start pulses mid-frame and in FIN.
    run_frame(1'b0, 1, 1'b1, 1'b0, $urandom, $urandom);
    // Reset in the middle of memory word 7, then a clean frame.
    mem[7] = 32'h0000_0777;
    run_frame(1'b0, 1, 1'b0, 1'b1, $urandom, $urandom);
    run_frame(1'b0, 0, 1'b0, 1'b0, $urandom, $urandom);
    // Sparse contents: only r2 and word 0 nonzero.
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    rf[2]  = 32'h5;
    mem[0] = 32'h9;
    run_frame(1'b0, 0, 1'b0, 1'b0, $urandom, $urandom);
    run_frame(1'b1, 0, 1'b0, 1'b0, $urandom, $urandom);
    // Random contents with many zeros, random backpressure.
    for (int k = 0; k < 3; k++) begin
      fill_random(40);
      run_frame(k[0], 1, k[1], 1'b0, $urandom, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
